gp_bus_sched: RTL and testbench

GP_BUS_SCHED -- requirements
Module: gp_bus_sched

---
 rtl/gp_bus_sched_pkg.sv | 29 ++
 rtl/gp_bus_sched_arb.sv | 24 ++
 rtl/gp_bus_sched.sv | 141 ++++++++++++++
 tb/tb_gp_bus_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gp_bus_sched_pkg.sv
// gp_bus_sched_pkg -- shared definitions for the general-purpose register bus
// scheduler: register/requester counts, index width, FSM state encodings and
// a one-hot decode helper.
// Optional feature macro: GP_BUS_SCHED_TURN_EN adds the TURN state that follows
// every DRIVE.
package gp_bus_sched_pkg;

  localparam int NUM_GP_REGS = 4;
  localparam int NUM_REQ     = 2;
  localparam int IDX_W       = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_DRIVE   = 3'd1;
  localparam state_t ST_WSETUP  = 3'd2;
  localparam state_t ST_WSTROBE = 3'd3;
`ifdef GP_BUS_SCHED_TURN_EN
  localparam state_t ST_TURN    = 3'd4;
`endif

  // One-hot select of a gp register from its index.
  function automatic logic [NUM_GP_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_GP_REGS-1:0] one;
    one = {{(NUM_GP_REGS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/gp_bus_sched_arb.sv
// rr_arb2 -- two-way round-robin picker.
// Ports:
//   valid [1:0] : requests present this cycle
//   last        : index of the requester served most recently
//   grant [1:0] : one-hot grant (all zero when nothing is valid)
// A lone request wins outright; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant decode from the request pattern and last-served pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/gp_bus_sched.sv
// gp_bus_sched -- schedules two requesters onto four gp registers. A read
// drives the selected register onto bus A (n_oe_a low for one cycle); a write
// sets up for one cycle and then strobes w_clk of the selected register.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   req_valid  : per-requester request
//   req_idx    : per-requester target register index
//   req_wr     : per-requester op (1 = write, 0 = read onto bus A)
//   req_ack    : one-cycle completion pulse per requester
//   n_oe_a     : active-low bus-A output enables
//   w_clk      : register write strobes (capture on rising edge)
//   busy       : high whenever the FSM is not idle
// Optional feature macro: GP_BUS_SCHED_TURN_EN inserts a one-cycle TURN
// (all enables high) after every DRIVE.
// Every output is a flop loaded from the next-state decode, so the outputs for
// a state appear in the same cycle the FSM is in that state.
module gp_bus_sched
  import gp_bus_sched_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]   req_idx,
  input  logic [NUM_REQ-1:0]              req_wr,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_GP_REGS-1:0]          n_oe_a,
  output logic [NUM_GP_REGS-1:0]          w_clk,
  output logic                            busy
);

  state_t                   state_r, state_nxt_s;
  logic                     last_r, last_nxt_s;
  logic [IDX_W-1:0]         op_idx_r, op_idx_nxt_s;
  logic                     op_req_r, op_req_nxt_s;
  logic [NUM_REQ-1:0]       ack_r, ack_nxt_s;
  logic [NUM_GP_REGS-1:0]   n_oe_r, n_oe_nxt_s;
  logic [NUM_GP_REGS-1:0]   w_clk_r, w_clk_nxt_s;
  logic                     busy_r;
  logic [NUM_REQ-1:0]       grant_s;
  logic [IDX_W-1:0]         sel_idx_s;
  logic                     sel_wr_s;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_r),
    .grant (grant_s)
  );

  // Select the granted requester's operation fields.
  always_comb begin
    if (grant_s[1]) begin
      sel_idx_s = req_idx[1];
      sel_wr_s  = req_wr[1];
    end else begin
      sel_idx_s = req_idx[0];
      sel_wr_s  = req_wr[0];
    end
  end

  // Next-state and next-output decode; outputs idle unless a state drives them.
  always_comb begin
    state_nxt_s  = ST_IDLE;
    last_nxt_s   = last_r;
    op_idx_nxt_s = op_idx_r;
    op_req_nxt_s = op_req_r;
    ack_nxt_s    = {NUM_REQ{1'b0}};
    n_oe_nxt_s   = {NUM_GP_REGS{1'b1}};
    w_clk_nxt_s  = {NUM_GP_REGS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (|grant_s) begin
          // Latch the operation so later input changes cannot disturb it.
          last_nxt_s   = grant_s[1];
          op_idx_nxt_s = sel_idx_s;
          op_req_nxt_s = grant_s[1];
          if (sel_wr_s) begin
            state_nxt_s = ST_WSETUP;
          end else begin
            state_nxt_s = ST_DRIVE;
            n_oe_nxt_s  = ~reg_onehot(sel_idx_s);
            ack_nxt_s   = grant_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
`ifdef GP_BUS_SCHED_TURN_EN
        state_nxt_s = ST_TURN;
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_WSETUP: begin
        state_nxt_s = ST_WSTROBE;
        w_clk_nxt_s = reg_onehot(op_idx_r);
        ack_nxt_s   = op_req_r ? 2'b10 : 2'b01;
      end
      ST_WSTROBE: begin
        state_nxt_s = ST_IDLE;
      end
`ifdef GP_BUS_SCHED_TURN_EN
      ST_TURN: begin
        state_nxt_s = ST_IDLE;
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, latched operation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      last_r   <= 1'b1;
      op_idx_r <= {IDX_W{1'b0}};
      op_req_r <= 1'b0;
      ack_r    <= {NUM_REQ{1'b0}};
      n_oe_r   <= {NUM_GP_REGS{1'b1}};
      w_clk_r  <= {NUM_GP_REGS{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= last_nxt_s;
      op_idx_r <= op_idx_nxt_s;
      op_req_r <= op_req_nxt_s;
      ack_r    <= ack_nxt_s;
      n_oe_r   <= n_oe_nxt_s;
      w_clk_r  <= w_clk_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign req_ack = ack_r;
  assign n_oe_a  = n_oe_r;
  assign w_clk   = w_clk_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_gp_bus_sched.sv
// tb_gp_bus_sched -- table-driven directed bench for gp_bus_sched. Each row
// holds inputs applied before a rising edge and the outputs expected after it.
// Expectations follow GP_BUS_SCHED_TURN_EN when it is defined.
module tb_gp_bus_sched;

  typedef struct {
    string      nm;
    logic       rst;
    logic [1:0] v;
    logic [1:0] i0;
    logic [1:0] i1;
    logic [1:0] wr;
    logic [1:0] ack;
    logic [3:0] noe;
    logic [3:0] wclk;
    logic       busy;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0][1:0] req_idx;
  logic [1:0]      req_wr;
  logic [1:0]      req_ack;
  logic [3:0]      n_oe_a;
  logic [3:0]      w_clk;
  logic            busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  gp_bus_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_wr    (req_wr),
    .req_ack   (req_ack),
    .n_oe_a    (n_oe_a),
    .w_clk     (w_clk),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string nm, input logic r, input logic [1:0] v,
                              input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] wr,
                              input logic [1:0] ack, input logic [3:0] noe,
                              input logic [3:0] wclk, input logic b);
    vec_t x;
    x.nm = nm; x.rst = r; x.v = v; x.i0 = i0; x.i1 = i1; x.wr = wr;
    x.ack = ack; x.noe = noe; x.wclk = wclk; x.busy = b;
    vecs.push_back(x);
  endfunction

  // Row for the TURN cycle that follows a DRIVE, only when TURN exists.
  function automatic void add_turn(input string nm, input logic [1:0] v,
                                   input logic [1:0] i0, input logic [1:0] i1);
`ifdef GP_BUS_SCHED_TURN_EN
    add(nm, 1'b0, v, i0, i1, 2'b00, 2'b00, 4'hF, 4'h0, 1'b1);
`endif
  endfunction

  // Drive one cycle of inputs (called at a falling edge), wait past the rising edge.
  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] i0,
                      input logic [1:0] i1, input logic [1:0] wr);
    rst = r; req_valid = v; req_idx[0] = i0; req_idx[1] = i1; req_wr = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] e_ack, input logic [3:0] e_noe,
                       input logic [3:0] e_wclk, input logic e_busy);
    checks++;
    if (req_ack !== e_ack) begin
      errors++; $display("FAIL %s req_ack got %b want %b", nm, req_ack, e_ack);
    end
    checks++;
    if (n_oe_a !== e_noe) begin
      errors++; $display("FAIL %s n_oe_a got %h want %h", nm, n_oe_a, e_noe);
    end
    checks++;
    if (w_clk !== e_wclk) begin
      errors++; $display("FAIL %s w_clk got %h want %h", nm, w_clk, e_wclk);
    end
    checks++;
    if (busy !== e_busy) begin
      errors++; $display("FAIL %s busy got %b want %b", nm, busy, e_busy);
    end
    checks++;
    if ($countones(~n_oe_a) > 1 || $countones(w_clk) > 1 ||
        (w_clk != 4'h0 && n_oe_a != 4'hF)) begin
      errors++; $display("FAIL %s exclusivity n_oe_a=%h w_clk=%h", nm, n_oe_a, w_clk);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_idx[0] = 2'd0; req_idx[1] = 2'd0; req_wr = 2'b00;

    // Reset held two cycles, then idle.
    add("reset0", 1'b1, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    add("reset1", 1'b1, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    add("idle",   1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    // Single read by requester 0 of register 2.
    add("rd_drive", 1'b0, 2'b01, 2'd2, 2'd0, 2'b00, 2'b01, 4'hB, 4'h0, 1'b1);
    add_turn("rd_turn", 2'b00, 2'd0, 2'd0);
    add("rd_idle", 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    // Write by requester 1 to register 1; valid drops and idx changes after grant.
    add("wr_setup",  1'b0, 2'b10, 2'd0, 2'd1, 2'b10, 2'b00, 4'hF, 4'h0, 1'b1);
    add("wr_strobe", 1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b10, 4'hF, 4'h2, 1'b1);
    add("wr_idle",   1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    // Contention: both reads held; grants alternate 0,1,0,1 (req1 served last).
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        add("cont_drive0", 1'b0, 2'b11, 2'd0, 2'd3, 2'b00, 2'b01, 4'hE, 4'h0, 1'b1);
      end else begin
        add("cont_drive1", 1'b0, 2'b11, 2'd0, 2'd3, 2'b00, 2'b10, 4'h7, 4'h0, 1'b1);
      end
      if (k < 3) begin
        add_turn("cont_turn", 2'b11, 2'd0, 2'd3);
        add("cont_idle", 1'b0, 2'b11, 2'd0, 2'd3, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
      end else begin
        add_turn("cont_turn", 2'b00, 2'd0, 2'd3);
        add("cont_idle", 1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
      end
    end
    // Lone requester 1 granted although it was served last.
    add("lone_drive", 1'b0, 2'b10, 2'd0, 2'd0, 2'b00, 2'b10, 4'hE, 4'h0, 1'b1);
    add_turn("lone_turn", 2'b00, 2'd0, 2'd0);
    add("lone_idle", 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    // Requester 1 pulses valid only while busy: withdrawn, never acked.
    add("wd_setup",  1'b0, 2'b01, 2'd3, 2'd1, 2'b01, 2'b00, 4'hF, 4'h0, 1'b1);
    add("wd_strobe", 1'b0, 2'b10, 2'd3, 2'd1, 2'b00, 2'b01, 4'hF, 4'h8, 1'b1);
    add("wd_idle0",  1'b0, 2'b00, 2'd3, 2'd1, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);
    add("wd_idle1",  1'b0, 2'b00, 2'd3, 2'd1, 2'b00, 2'b00, 4'hF, 4'h0, 1'b0);

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].rst, vecs[n].v, vecs[n].i0, vecs[n].i1, vecs[n].wr);
      check(vecs[n].nm, vecs[n].ack, vecs[n].noe, vecs[n].wclk, vecs[n].busy);
      @(negedge clk);
    end

    // Reset while in WSETUP: no strobe ever appears, no ack.
    step(1'b0, 2'b01, 2'd2, 2'd0, 2'b01);
    check("rs_setup", 2'b00, 4'hF, 4'h0, 1'b1);
    @(negedge clk);
    step(1'b1, 2'b00, 2'd2, 2'd0, 2'b00);
    check("rst_in_setup", 2'b00, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    step(1'b0, 2'b00, 2'd2, 2'd0, 2'b00);
    check("rst_setup_after", 2'b00, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    // Reset while in WSTROBE: w_clk falls at the reset edge.
    step(1'b0, 2'b01, 2'd2, 2'd0, 2'b01);
    check("rs2_setup", 2'b00, 4'hF, 4'h0, 1'b1);
    @(negedge clk);
    step(1'b0, 2'b00, 2'd2, 2'd0, 2'b00);
    check("rs2_strobe", 2'b01, 4'hF, 4'h4, 1'b1);
    @(negedge clk);
    step(1'b1, 2'b00, 2'd2, 2'd0, 2'b00);
    check("rst_in_strobe", 2'b00, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    step(1'b0, 2'b00, 2'd2, 2'd0, 2'b00);
    check("rst_strobe_after", 2'b00, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    // Pointer restored by reset: tie goes to requester 0.
    step(1'b0, 2'b11, 2'd1, 2'd2, 2'b00);
    check("ptr_after_rst", 2'b01, 4'hD, 4'h0, 1'b1);
    @(negedge clk);
    step(1'b0, 2'b00, 2'd1, 2'd2, 2'b00);
`ifdef GP_BUS_SCHED_TURN_EN
    check("ptr_turn", 2'b00, 4'hF, 4'h0, 1'b1);
`else
    check("ptr_idle", 2'b00, 4'hF, 4'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
